// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI core: sequencer states, CPHA encodings
// and edge-counter sizing.
package spi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StDone
    } spi_state_e;

    localparam logic CPHA_SAMPLE_LEAD = 1'b0;
    localparam logic CPHA_SHIFT_LEAD  = 1'b1;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned EDGE_W = $clog2(2 * DEFAULT_DATA_WIDTH + 1);

    // Width needed to count SCK edges 0..2N without wrapping.
    function automatic int unsigned edge_width(input int unsigned data_width);
        return $clog2(2 * data_width + 1);
    endfunction

endpackage

// File: rtl/spi_baud_counter.sv
// Reload/decrement divider: ticks once every div+1 enabled cycles after a load.
// Also used by the slave-side timeout logic.
module spi_baud_counter #(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_load,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 w_zero;

    assign w_zero = (r_cnt == '0);
    assign o_tick = i_en && !i_load && w_zero;

    // A new divider value is only picked up on load or on the reload after a tick.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_div;
        end else if (i_en) begin
            if (w_zero) begin
                r_cnt <= i_div;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_sequencer.sv
// Master-mode SPI transfer sequencer: generates SCK, slave select, shift/sample
// strobes, idle flag, completion and write-collision pulses.
module spi_master_sequencer
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIV_WIDTH  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_mstr,
    input  logic                 i_spe,
    input  logic                 i_cpol,
    input  logic                 i_cpha,
    input  logic [DIV_WIDTH-1:0] i_baud_div,
    input  logic                 i_start,
    output logic                 o_sck,
    output logic                 o_ss_n,
    output logic                 o_shift_en,
    output logic                 o_sample_en,
    output logic                 o_idle,
    output logic                 o_done,
    output logic                 o_wcol
);

    localparam int unsigned EdgeW = edge_width(DATA_WIDTH);
    localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_WIDTH);

    spi_state_e       r_state;
    logic [EdgeW-1:0] r_edge_cnt;
    logic             r_sck_tog;
    logic             r_ss_n;
    logic             r_shift_en;
    logic             r_sample_en;
    logic             r_idle;
    logic             r_done;
    logic             r_wcol;

    logic             w_enable;
    logic             w_go;
    logic             w_run;
    logic             w_tick;
    logic [EdgeW-1:0] w_edge_nxt;
    logic             w_last;
    logic             w_leading;

    assign w_enable   = i_mstr && i_spe;
    assign w_go       = (r_state == StIdle) && i_start && w_enable;
    assign w_run      = (r_state == StActive) && w_enable;
    assign w_edge_nxt = r_edge_cnt + EdgeW'(1);
    assign w_last     = (w_edge_nxt == LastEdge);
    assign w_leading  = w_edge_nxt[0];

    spi_baud_counter #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_counter (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (w_run),
        .i_load (w_go),
        .i_div  (i_baud_div),
        .o_tick (w_tick)
    );

    // sck follows cpol combinationally so it tracks cpol changes while idle.
    assign o_sck       = i_cpol ^ r_sck_tog;
    assign o_ss_n      = r_ss_n;
    assign o_shift_en  = r_shift_en;
    assign o_sample_en = r_sample_en;
    assign o_idle      = r_idle;
    assign o_done      = r_done;
    assign o_wcol      = r_wcol;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_edge_cnt  <= '0;
            r_sck_tog   <= 1'b0;
            r_ss_n      <= 1'b1;
            r_shift_en  <= 1'b0;
            r_sample_en <= 1'b0;
            r_idle      <= 1'b1;
            r_done      <= 1'b0;
            r_wcol      <= 1'b0;
        end else begin
            r_shift_en  <= 1'b0;
            r_sample_en <= 1'b0;
            r_done      <= 1'b0;
            r_wcol      <= i_start && (r_state != StIdle);

            case (r_state)
                StIdle: begin
                    if (w_go) begin
                        r_state    <= StActive;
                        r_edge_cnt <= '0;
                        r_sck_tog  <= 1'b0;
                        r_ss_n     <= 1'b0;
                        r_idle     <= 1'b0;
                    end
                end

                StActive: begin
                    if (!w_enable) begin
                        r_state   <= StIdle;
                        r_sck_tog <= 1'b0;
                        r_ss_n    <= 1'b1;
                        r_idle    <= 1'b1;
                    end else if (w_tick) begin
                        r_sck_tog  <= ~r_sck_tog;
                        r_edge_cnt <= w_edge_nxt;
                        // CPHA=0 preloads bit 0 on start, so the final trailing edge has no shift.
                        if (i_cpha == CPHA_SAMPLE_LEAD) begin
                            r_sample_en <= w_leading;
                            r_shift_en  <= !w_leading && !w_last;
                        end else begin
                            r_shift_en  <= w_leading;
                            r_sample_en <= !w_leading;
                        end
                        if (w_last) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end
                    end
                end

                StDone: begin
                    r_state   <= StIdle;
                    r_sck_tog <= 1'b0;
                    r_ss_n    <= 1'b1;
                    r_idle    <= 1'b1;
                end

                default: begin
                    r_state   <= StIdle;
                    r_sck_tog <= 1'b0;
                    r_ss_n    <= 1'b1;
                    r_idle    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_master_sequencer.md
Name: spi_master_sequencer

Overview:
- Master-mode transfer sequencer for the SPI core. Runs one DATA_WIDTH-bit transfer per accepted start.
- Generates SCK, which idles at CPOL and has a programmable half-period.
- Generates single-cycle shift_en/sample_en strobes per CPHA for the shift register, plus busy/idle, slave select and a completion pulse.
- Sits between the register file (SPCR/SPDR write) and the master/slave clock-select mux. It supplies the master-side shift/sample strobes and the idle flag.

Parameters:
- DATA_WIDTH, 8, bits per transfer (N)
- DIV_WIDTH, 8, width of baud divider field

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mstr  in  1  1 = master mode; 0 forces sequencer idle
- spe  in  1  SPI enable; 0 forces sequencer idle
- cpol  in  1  SCK idle level
- cpha  in  1  0 = sample on leading edge; 1 = shift on leading edge
- baud_div  in  DIV_WIDTH  SCK half-period minus 1, in clk cycles
- start  in  1  one-cycle pulse on SPDR write
- sck  out  1  serial clock
- ss_n  out  1  slave select, active low
- shift_en  out  1  one-cycle strobe: shift next bit out
- sample_en  out  1  one-cycle strobe: sample MISO
- idle  out  1  high in IDLE state
- done  out  1  one-cycle transfer-complete pulse (sets SPIF)
- wcol  out  1  one-cycle write-collision pulse

Behaviour:
- Reset: state = IDLE, sck = cpol, ss_n = 1, shift_en = sample_en = done = wcol = 0, idle = 1, div_cnt = 0, edge_cnt = 0.
- All outputs are registered except sck, which equals cpol ^ sck_tog, where sck_tog is a register. This makes sck follow cpol immediately while idle.
- States: IDLE, ACTIVE, DONE.
- IDLE -> ACTIVE when start & mstr & spe.
  - On that edge: div_cnt = baud_div, edge_cnt = 0, sck_tog = 0, ss_n = 0, idle = 0.
- ACTIVE, each cycle:
  - If div_cnt != 0: div_cnt decrements.
  - If div_cnt == 0: edge event. sck_tog toggles, edge_cnt increments, div_cnt reloads baud_div.
  - Half-period is therefore baud_div+1 clk cycles. baud_div = 0 gives SCK = clk/2.
- Edge k (1..2N, odd = leading). The strobe is registered, so it is high in the cycle the new sck level is first visible.
  - CPHA=0: odd k -> sample_en; even k < 2N -> shift_en. The first bit is loaded by the shift register on start, not by a strobe.
  - CPHA=1: odd k -> shift_en; even k -> sample_en.
  - Per transfer: N sample_en pulses. Shift_en count is N-1 for CPHA=0 and N for CPHA=1.
- Edge 2N -> DONE. done = 1 in that same cycle; ss_n stays 0.
- DONE -> IDLE unconditionally after 1 cycle: idle = 1, ss_n = 1.
  - Start-to-done latency: 1 + 2N(baud_div+1) cycles.
- wcol = 1 for one cycle when start arrives in ACTIVE or DONE. The start is ignored and the transfer is unaffected.
- Start in IDLE with mstr = 0 or spe = 0: ignored, no wcol.
- mstr or spe falling in ACTIVE/DONE: abort to IDLE next cycle.
  - sck_tog = 0, ss_n = 1, no done, no strobes in the abort cycle.
- baud_div changes mid-transfer take effect at the next reload only.
- cpol/cpha changes mid-transfer are unsupported; the register file blocks them while idle = 0. The bench must not drive them.
- Reset mid-transfer: all outputs return to reset values on the next clk edge.
- edge_cnt width: clog2(2N+1). The counter never wraps because it stops at 2N.

Decomposition:
- Shared package spi_pkg:
  - state enum {IDLE, ACTIVE, DONE}
  - EDGE_W = clog2(2*DATA_WIDTH+1)
  - CPHA encodings
- Sub-module spi_baud_counter, reused by the slave-side timeout logic:
  - reload/decrement counter
  - ports: clk, rst, en, load, div, tick

Test Plan:
1. Basic CPHA=0: N=8, baud_div=1, cpol=0, cpha=0, start at cycle 0 -> sck rises at cycle 3, toggles every 2 cycles, 16 edges. Expect 8 sample_en pulses (rising edges), 7 shift_en pulses, done at cycle 33, idle = 1 and ss_n = 1 at cycle 34.
2. CPHA=1 / CPOL=1: cpol=1, cpha=1, baud_div=0 -> sck idles high. Expect 8 shift_en pulses on falling (leading) edges, 8 sample_en pulses on rising edges, done at cycle 17.
3. Write collision: start pulsed at cycle 10 of scenario 1 -> wcol = 1 at cycle 11, done still at cycle 33, exactly one transfer.
4. Abort: spe dropped at cycle 12 -> idle = 1, ss_n = 1, sck = cpol at cycle 13; no done. A new start afterwards runs a full transfer.
5. Slave mode: mstr=0, start pulsed -> no state change, no wcol, sck = cpol, ss_n = 1 throughout.
6. Reset and divider change: rst asserted mid-transfer -> all outputs at reset values next cycle. Separately, baud_div changed 1 -> 3 mid-transfer -> the following half-periods are 4 cycles.
